// File: rtl/chroma_key_ctrl.sv
// rtl/chroma_key_ctrl.sv - chroma-key threshold shadow/commit controller with optional auto-calibration
// Optional feature macro: CHROMA_KEY_AUTOCAL_EN (calibration FSM and window counters)
module chroma_key_ctrl #(
  parameter logic [7:0]  G_MIN_DEF  = 8'd100,
  parameter logic [7:0]  RG_MAX_DEF = 8'd80,
  parameter logic [7:0]  MARGIN     = 8'd20,
  parameter logic [11:0] WIN_X0     = 12'd608,
  parameter logic [11:0] WIN_Y0     = 12'd328,
  parameter logic [11:0] WIN_W      = 12'd64,
  parameter logic [11:0] WIN_H      = 12'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb_data,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic [7:0]  G_min,
  output logic [7:0]  RG_max,
  output logic        key_en,
  output logic        calib_busy,
  output logic        calib_done,
  output logic        calib_err
);

  logic       vsync_d1;
  logic       vs_rise;
  logic       wr_fire;
  logic [7:0] sh_g;
  logic [7:0] sh_rg;
  logic       sh_key;
  logic       cal_load;
  logic [7:0] cal_g;
  logic [7:0] cal_rg;
  logic       unused_sink;

  assign vs_rise = i_vsync & ~vsync_d1;
  assign wr_fire = wr_en & wr_ready;

`ifdef CHROMA_KEY_AUTOCAL_EN
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, CALC} state_t;

  state_t      state_q, state_d;
  logic [11:0] x_q, y_q;
  logic        de_d1;
  logic [7:0]  g_lo_q, rb_hi_q;
  logic        hit_q;
  logic        done_q, err_q;
  logic [7:0]  pix_r, pix_g, pix_b, rb_px;
  logic        in_win;
  logic [8:0]  g_sub, rb_add;
  logic        cal_ok;
  logic        end_frame;

  assign pix_r = rgb_data[23:16];
  assign pix_g = rgb_data[15:8];
  assign pix_b = rgb_data[7:0];
  assign rb_px = (pix_r > pix_b) ? pix_r : pix_b;

  // 13-bit compare so the window's right/bottom edge cannot wrap
  assign in_win = i_de
                && (x_q >= WIN_X0) && ({1'b0, x_q} < ({1'b0, WIN_X0} + {1'b0, WIN_W}))
                && (y_q >= WIN_Y0) && ({1'b0, y_q} < ({1'b0, WIN_Y0} + {1'b0, WIN_H}));

  assign g_sub     = {1'b0, g_lo_q} - {1'b0, MARGIN};
  assign rb_add    = {1'b0, rb_hi_q} + {1'b0, MARGIN};
  assign cal_g     = g_sub[8] ? 8'd0 : g_sub[7:0];
  assign cal_rg    = rb_add[8] ? 8'hFF : rb_add[7:0];
  assign cal_ok    = hit_q && (cal_g > cal_rg);
  assign end_frame = (state_q == SAMPLE) && vs_rise;
  assign cal_load  = end_frame && cal_ok;

  always_comb begin
    state_d    = state_q;
    wr_ready   = (state_q == IDLE);
    calib_busy = (state_q != IDLE);
    case (state_q)
      IDLE:    if (wr_fire && (wr_addr == 2'd2) && wr_data[1]) state_d = WAIT;
      WAIT:    if (vs_rise) state_d = SAMPLE;
      SAMPLE:  if (vs_rise) state_d = CALC;
      default: state_d = IDLE;
    endcase
  end

  assign calib_done = done_q;
  assign calib_err  = err_q;

  // Result is registered at the frame-ending edge so pulse and thresholds appear together in CALC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      de_d1   <= 1'b0;
      g_lo_q  <= 8'hFF;
      rb_hi_q <= 8'd0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      de_d1   <= i_de;
      done_q  <= end_frame && cal_ok;
      err_q   <= end_frame && !cal_ok;

      if (vs_rise) begin
        x_q <= 12'd0;
        y_q <= 12'd0;
      end else if (i_de) begin
        if (x_q != 12'hFFF) x_q <= x_q + 12'd1;
      end else if (de_d1) begin
        x_q <= 12'd0;
        if (y_q != 12'hFFF) y_q <= y_q + 12'd1;
      end

      if ((state_q == WAIT) && vs_rise) begin
        g_lo_q  <= 8'hFF;
        rb_hi_q <= 8'd0;
        hit_q   <= 1'b0;
      end else if ((state_q == SAMPLE) && !vs_rise && in_win) begin
        if (pix_g < g_lo_q)  g_lo_q  <= pix_g;
        if (rb_px > rb_hi_q) rb_hi_q <= rb_px;
        hit_q <= 1'b1;
      end
    end
  end

  assign unused_sink = ^{i_hsync, wr_data[7:2]};
`else
  assign cal_load   = 1'b0;
  assign cal_g      = 8'd0;
  assign cal_rg     = 8'd0;
  assign wr_ready   = 1'b1;
  assign calib_busy = 1'b0;
  assign calib_done = 1'b0;
  assign calib_err  = 1'b0;

  assign unused_sink = ^{i_hsync, wr_data[7:1], rgb_data, i_de, MARGIN,
                         WIN_X0, WIN_Y0, WIN_W, WIN_H};
`endif

  // Commit reads the shadow before any same-cycle write lands; calibration overrides both
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d1 <= 1'b0;
      sh_g     <= G_MIN_DEF;
      sh_rg    <= RG_MAX_DEF;
      sh_key   <= 1'b1;
      G_min    <= G_MIN_DEF;
      RG_max   <= RG_MAX_DEF;
      key_en   <= 1'b1;
    end else begin
      vsync_d1 <= i_vsync;
      if (vs_rise) begin
        G_min  <= sh_g;
        RG_max <= sh_rg;
        key_en <= sh_key;
      end
      if (wr_fire) begin
        case (wr_addr)
          2'd0:    sh_g   <= wr_data;
          2'd1:    sh_rg  <= wr_data;
          2'd2:    sh_key <= wr_data[0];
          default: ;
        endcase
      end
      if (cal_load) begin
        sh_g   <= cal_g;
        sh_rg  <= cal_rg;
        G_min  <= cal_g;
        RG_max <= cal_rg;
      end
    end
  end

endmodule

// File: tb/tb_chroma_key_ctrl.sv
// tb/tb_chroma_key_ctrl.sv - self-checking bench for chroma_key_ctrl
// Follows CHROMA_KEY_AUTOCAL_EN to select the expected calibration behaviour.
module tb_chroma_key_ctrl;

  localparam int LINE_W = 8;
  localparam logic [23:0] GREEN_PIX = {8'd30, 8'd200, 8'd40};
  localparam logic [23:0] HOT_PIX   = {8'd240, 8'd250, 8'd10};
  localparam logic [23:0] OUT_PIX   = {8'd255, 8'd0, 8'd255};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] rgb_data;
  logic        i_hsync, i_vsync, i_de, wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready, key_en, calib_busy, calib_done, calib_err;
  logic [7:0]  G_min, RG_max;

  always #5 clk = ~clk;

  chroma_key_ctrl #(
    .WIN_X0(12'd2), .WIN_Y0(12'd1), .WIN_W(12'd3), .WIN_H(12'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rgb_data(rgb_data), .i_hsync(i_hsync),
    .i_vsync(i_vsync), .i_de(i_de), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .G_min(G_min), .RG_max(RG_max),
    .key_en(key_en), .calib_busy(calib_busy), .calib_done(calib_done),
    .calib_err(calib_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_done_seen = 0;
  bit chk_en = 0;

  // Expected outputs and host-visible state; phase 0 idle, 1 armed, 2 sampling, 3 result cycle
  logic [7:0] m_sh_g, m_sh_rg, e_g, e_rg;
  logic       m_sh_key, e_key, e_ready, e_busy, e_done, e_err;
  int         m_phase, m_min_g, m_max_rb;
  bit         m_hit;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("G_min", G_min, e_g);
      check("RG_max", RG_max, e_rg);
      check("key_en", key_en, e_key);
      check("wr_ready", wr_ready, e_ready);
      check("calib_busy", calib_busy, e_busy);
      check("calib_done", calib_done, e_done);
      check("calib_err", calib_err, e_err);
      if (calib_done) n_done_seen++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_sh_g = 8'd100; m_sh_rg = 8'd80; m_sh_key = 1'b1;
    e_g = 8'd100; e_rg = 8'd80; e_key = 1'b1;
    e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    m_phase = 0;
  endtask

  task automatic accept(input logic [1:0] a, input logic [7:0] d);
    case (a)
      2'd0: m_sh_g = d;
      2'd1: m_sh_rg = d;
      2'd2: begin
        m_sh_key = d[0];
`ifdef CHROMA_KEY_AUTOCAL_EN
        if (d[1]) begin m_phase = 1; e_ready = 1'b0; e_busy = 1'b1; end
`endif
      end
      default: ;
    endcase
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    bit acc;
    acc = e_ready;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
    if (acc) accept(a, d);
  endtask

  // One frame: vsync pulse (optionally with a colliding write), then nlines of LINE_W pixels
  task automatic frame(input int nlines, input logic [23:0] pin, input logic [23:0] pout,
                       input bit do_wr, input logic [1:0] wa, input logic [7:0] wd);
    bit acc;
    bit inw;
    int cg, crg, rb;
    acc = do_wr && e_ready;
    i_vsync = 1'b1;
    if (do_wr) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
    tick;
    wr_en = 1'b0;
    e_g = m_sh_g; e_rg = m_sh_rg; e_key = m_sh_key;
    if (m_phase == 2) begin
      cg  = m_min_g - 20;   if (cg < 0) cg = 0;
      crg = m_max_rb + 20;  if (crg > 255) crg = 255;
      if (m_hit && cg > crg) begin
        e_g = 8'(cg); e_rg = 8'(crg); m_sh_g = 8'(cg); m_sh_rg = 8'(crg); e_done = 1'b1;
      end else begin
        e_err = 1'b1;
      end
      m_phase = 3;
    end else if (m_phase == 1) begin
      m_phase = 2; m_min_g = 255; m_max_rb = 0; m_hit = 0;
    end
    if (acc) accept(wa, wd);
    tick;
    if (m_phase == 3) begin
      m_phase = 0; e_done = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
    end
    i_vsync = 1'b0;
    tick; tick;
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < LINE_W; c++) begin
        inw = (l >= 1) && (l < 3) && (c >= 2) && (c < 5);
        i_de = 1'b1;
        rgb_data = inw ? pin : pout;
        if (m_phase == 2 && inw) begin
          if (int'(pin[15:8]) < m_min_g) m_min_g = int'(pin[15:8]);
          rb = (pin[23:16] > pin[7:0]) ? int'(pin[23:16]) : int'(pin[7:0]);
          if (rb > m_max_rb) m_max_rb = rb;
          m_hit = 1;
        end
        tick;
      end
      i_de = 1'b0; rgb_data = 24'd0;
      repeat (3) tick;
    end
  endtask

  initial begin
    rst_n = 1'b0; rgb_data = 24'd0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
    m_min_g = 255; m_max_rb = 0; m_hit = 0;
    model_reset;
    tick; tick;
    rst_n = 1'b1;
    chk_en = 1;
    tick;
    check("rst_G_min_lit", G_min, 100);
    check("rst_RG_max_lit", RG_max, 80);
    check("rst_key_en_lit", key_en, 1);
    check("rst_wr_ready_lit", wr_ready, 1);

    // Mid-frame write waits for the next frame boundary
    frame(2, OUT_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    host_write(2'd0, 8'd150);
    tick;
    check("hold_G_min_lit", G_min, 100);
    frame(2, OUT_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    check("commit_G_min_lit", G_min, 150);

    // Write on the vs_rise cycle lands one frame later
    frame(2, OUT_PIX, OUT_PIX, 1, 2'd0, 8'd170);
    check("coll_hold_lit", G_min, 150);
    frame(2, OUT_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    check("coll_apply_lit", G_min, 170);

    // key_en off, address 3 ignored, key_en back on
    host_write(2'd2, 8'd0);
    host_write(2'd3, 8'h55);
    frame(2, OUT_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    check("key_off_lit", key_en, 0);
    host_write(2'd2, 8'd1);
    frame(2, OUT_PIX, OUT_PIX, 0, 2'd0, 8'd0);

    // Successful calibration on a green window
    host_write(2'd2, 8'h03);
    frame(4, GREEN_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    frame(4, GREEN_PIX, OUT_PIX, 0, 2'd0, 8'd0);
`ifdef CHROMA_KEY_AUTOCAL_EN
    check("cal_G_min_lit", G_min, 180);
    check("cal_RG_max_lit", RG_max, 60);
`else
    check("nocal_G_min_lit", G_min, 170);
    check("nocal_RG_max_lit", RG_max, 80);
`endif

    // Window not green enough: error, thresholds unchanged
    host_write(2'd2, 8'h03);
    frame(4, HOT_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    frame(4, HOT_PIX, OUT_PIX, 0, 2'd0, 8'd0);

    // Frame too short to reach the window; writes while busy are dropped
    host_write(2'd2, 8'h03);
    host_write(2'd0, 8'd33);
    frame(1, GREEN_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    host_write(2'd1, 8'd44);
    frame(1, GREEN_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    frame(1, OUT_PIX, OUT_PIX, 0, 2'd0, 8'd0);
`ifdef CHROMA_KEY_AUTOCAL_EN
    check("short_G_min_lit", G_min, 180);
    check("short_RG_max_lit", RG_max, 60);
`else
    check("short_G_min_lit", G_min, 33);
    check("short_RG_max_lit", RG_max, 44);
`endif

    // Reset during sampling aborts silently and restores defaults
    host_write(2'd0, 8'd150);
    frame(2, OUT_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    host_write(2'd2, 8'h03);
    frame(4, GREEN_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    rst_n = 1'b0;
    tick;
    model_reset;
    rst_n = 1'b1;
    check("abort_G_min_lit", G_min, 100);
    check("abort_busy_lit", calib_busy, 0);
    frame(2, GREEN_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    frame(2, GREEN_PIX, OUT_PIX, 0, 2'd0, 8'd0);
    check("final_RG_max_lit", RG_max, 80);
`ifdef CHROMA_KEY_AUTOCAL_EN
    check("done_pulses_lit", n_done_seen, 1);
`else
    check("done_pulses_lit", n_done_seen, 0);
`endif

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
